// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests the word at the current PC, waits for a variable-latency
// response, holds it for the decoder and advances the PC once per consumed instruction.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic        pc_enable,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  output logic        misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_aligned;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_misaligned;

  assign w_aligned = (pc_in[1:0] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: w_next_state = S_REQ;
      S_REQ: begin
        if (!w_aligned) begin
          w_next_state = S_HOLD;
        end else if (mem_req_ready) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush arriving together with the response discards it; nothing is left to drain.
        if (mem_rsp_valid) begin
          w_next_state = flush ? S_REQ : S_HOLD;
        end else if (flush) begin
          w_next_state = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush || instr_ready) begin
          w_next_state = S_REQ;
        end
      end
      S_DROP: begin
        if (mem_rsp_valid) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'h0;
    instr_valid   = 1'b0;
    pc_enable     = 1'b0;
    unique case (r_state)
      S_REQ: begin
        if (w_aligned) begin
          mem_req_valid = 1'b1;
          mem_req_addr  = pc_in;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        pc_enable   = instr_ready & ~flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr      <= RESET_INSTR;
      r_instr_pc   <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (!w_aligned) begin
            r_instr      <= RESET_INSTR;
            r_instr_pc   <= pc_in;
            r_misaligned <= 1'b1;
          end else if (mem_req_ready) begin
            r_instr_pc <= pc_in;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid && !flush) begin
            r_instr      <= mem_rsp_data;
            r_misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr      = r_instr;
  assign instr_pc   = r_instr_pc;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then randomized traffic, all checked
// cycle by cycle against a transaction-level model of the fetch slot, PC and memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic        pc_enable;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic        misaligned;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_INSTR(NOP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_in        (pc_in),
    .pc_enable    (pc_enable),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .flush        (flush),
    .misaligned   (misaligned)
  );

  // Model of the single fetch slot: in reset, starting up, empty, request outstanding, or held.
  typedef enum {M_RST, M_START, M_EMPTY, M_OUT, M_HELD} slot_t;

  slot_t       ph;
  logic [31:0] pc_model;
  logic [31:0] out_addr;
  logic        out_dead;
  int          lat_cnt;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  logic        held_mis;
  bit          random_pc;
  logic [31:0] redirect_q[$];
  logic [31:0] mem_over[logic [31:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int n_enable_seen = 0;
  int n_consumed = 0;
  int n_dropped_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] cur);
    int r;
    if (redirect_q.size() > 0) return redirect_q.pop_front();
    if (!random_pc) return cur + 32'd4;
    r = $urandom_range(0, 99);
    if (r < 70) return cur + 32'd4;
    if (r < 92) return $urandom & 32'h0000_0FFC;
    return ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
  endfunction

  function automatic logic [31:0] flush_target();
    if (redirect_q.size() > 0) return redirect_q.pop_front();
    return $urandom & 32'h0000_0FFC;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_enable"}, pc_enable, 1'b0);
    check({tag, "_req_valid"}, mem_req_valid, 1'b0);
    check({tag, "_req_addr"}, mem_req_addr, 32'h0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_instr_valid"}, instr_valid, 1'b0);
    check({tag, "_misaligned"}, misaligned, 1'b0);
  endtask

  // Asserts reset at posedge+1, optionally with a stray response in flight, and releases it
  // at posedge+1 after the given number of clock edges.
  task automatic do_reset(input int cycles, input logic pulse_rsp);
    reset_n       = 1'b0;
    ph            = M_RST;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b0;
    flush         = 1'b0;
    mem_rsp_valid = pulse_rsp;
    mem_rsp_data  = 32'hCAFE_BABE;
    #1;
    check_reset_outputs("rst_enter");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
    end
    check_reset_outputs("rst_hold");
    reset_n  = 1'b1;
    ph       = M_START;
    pc_model = 32'h0;
    pc_in    = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic rdy, input logic irdy, input logic fl, input logic spur,
                      input int lat);
    logic rsp;
    logic e_rv;
    logic e_v;
    logic e_en;
    rsp           = (ph == M_OUT) && (lat_cnt == 0);
    pc_in         = pc_model;
    mem_req_ready = rdy;
    instr_ready   = irdy;
    flush         = fl;
    mem_rsp_valid = rsp || (spur && ph != M_OUT);
    mem_rsp_data  = rsp ? mem_word(out_addr) : $urandom;
    #2;
    e_rv = (ph == M_EMPTY) && (pc_model[1:0] == 2'b00);
    e_v  = (ph == M_HELD);
    e_en = e_v && irdy && !fl;
    check("req_valid", mem_req_valid, e_rv);
    if (e_rv) check("req_addr", mem_req_addr, pc_model);
    check("instr_valid", instr_valid, e_v);
    check("pc_enable", pc_enable, e_en);
    if (e_v) begin
      check("instr", instr, held_instr);
      check("instr_pc", instr_pc, held_pc);
      check("misaligned", misaligned, held_mis);
    end
    if (pc_enable) n_enable_seen++;
    if (instr_valid && instr == 32'hDEAD_BEEF) n_dropped_seen++;

    case (ph)
      M_START: ph = M_EMPTY;
      M_EMPTY: begin
        if (pc_model[1:0] != 2'b00) begin
          held_pc    = pc_model;
          held_instr = NOP;
          held_mis   = 1'b1;
          ph         = M_HELD;
        end else if (rdy) begin
          out_addr = pc_model;
          out_dead = 1'b0;
          lat_cnt  = lat;
          ph       = M_OUT;
        end
      end
      M_OUT: begin
        if (rsp) begin
          if (fl || out_dead) begin
            ph = M_EMPTY;
          end else begin
            held_pc    = out_addr;
            held_instr = mem_word(out_addr);
            held_mis   = 1'b0;
            ph         = M_HELD;
          end
        end else begin
          lat_cnt--;
          if (fl) out_dead = 1'b1;
        end
        if (fl) pc_model = flush_target();
      end
      M_HELD: begin
        if (fl) begin
          ph       = M_EMPTY;
          pc_model = flush_target();
        end else if (irdy) begin
          ph = M_EMPTY;
          n_consumed++;
          pc_model = next_pc(pc_model);
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    random_pc = 1'b0;
    mem_over[32'h0]  = 32'h0050_0093;
    mem_over[32'h10] = 32'hDEAD_BEEF;

    #1;
    do_reset(3, 1'b0);

    // Single fetch from 0x0, consumed immediately; then 0x4 is fetched and flushed in HOLD.
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("after_first_pc", pc_model, 32'h4);
    redirect_q.push_back(32'h8);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);

    // Backpressure at 0x8 for three cycles, accepted on the fourth.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("before_flush_pc", pc_model, 32'h10);

    // Flush while waiting on 0x10; the DEADBEEF response must be dropped, next fetch is 0x40.
    redirect_q.push_back(32'h40);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("after_flush_pc", pc_model, 32'h40);
    redirect_q.push_back(32'h6);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Misaligned PC 0x6: no request, NOP held with misaligned set.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("mis_instr", instr, NOP);
    check("mis_pc", instr_pc, 32'h6);
    check("mis_flag", misaligned, 1'b1);
    redirect_q.push_back(32'h100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Reset while a request is outstanding; the late response must not be delivered.
    step(1'b1, 1'b0, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_reset(2, 1'b1);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("restart_pc", pc_model, 32'h4);
    check("dropped_never_valid", n_dropped_seen, 0);

    // Randomized traffic: backpressure, latency, flushes, stray responses, jumps.
    random_pc = 1'b1;
    mem_over.delete(32'h10);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10,
           $urandom_range(0, 3));
    end

    check("enable_count", n_enable_seen, n_consumed);
    check("progress", n_consumed > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
